// File: rtl/rx_fifo_packer_if.sv
// rx_fifo_packer_if
//  Groups the byte-wide receive handshake (in_*) and the wide FWFT output
//  handshake (out_*) of rx_fifo_packer into one bundle.
//  Ports (as seen from the packer, modport slave):
//   in_vld   in   byte valid
//   in_data  in   IN_WIDTH-bit byte
//   in_last  in   byte ends a packet
//   in_rdy   out  packer can accept a byte
//   out_vld  out  FIFO head word valid
//   out_data out  OUT_WIDTH-bit head word
//   out_last out  head word ends a packet
//   out_cnt  out  valid bytes in head word (1..OUT_WIDTH/IN_WIDTH)
//   out_rdy  in   consumer accepts head word
//  modport master is the mirror image, used by whatever drives and consumes the packer.
interface rx_fifo_packer_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 128
);
    localparam int CNT_WIDTH = $clog2(OUT_WIDTH / IN_WIDTH) + 1;

    logic                 in_vld;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 in_rdy;
    logic                 out_vld;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [CNT_WIDTH-1:0] out_cnt;
    logic                 out_rdy;

    modport slave (
        input  in_vld, in_data, in_last, out_rdy,
        output in_rdy, out_vld, out_data, out_last, out_cnt
    );

    modport master (
        output in_vld, in_data, in_last, out_rdy,
        input  in_rdy, out_vld, out_data, out_last, out_cnt
    );
endinterface

// File: rtl/rx_fifo_packer.sv
// rx_fifo_packer
//  Packs a little-endian byte stream into OUT_WIDTH-bit words and buffers them
//  in a 2**DEPTH_WIDTH-entry first-word-fall-through FIFO. A packet ends on
//  in_last; a partial final word is zero-padded above its last byte and tagged
//  with its byte count.
//  Ports:
//   clk    in   single clock
//   rst_n  in   asynchronous active-low reset
//   bus    if   rx_fifo_packer_if.slave (in_* byte side, out_* word side)
//   level  out  words currently stored in the FIFO, 0..2**DEPTH_WIDTH
module rx_fifo_packer #(
    parameter int IN_WIDTH    = 8,
    parameter int OUT_WIDTH   = 128,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_fifo_packer_if.slave      bus,
    output logic [DEPTH_WIDTH:0] level
);
    localparam int BYTES = OUT_WIDTH / IN_WIDTH;
    localparam int IDX_W = $clog2(BYTES);
    localparam int CNT_W = IDX_W + 1;
    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] LEVEL_FULL = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_LANE  = IDX_W'(BYTES - 1);

    typedef struct packed {
        logic                 last;
        logic [CNT_W-1:0]     cnt;
        logic [OUT_WIDTH-1:0] data;
    } entry_t;

    logic [IDX_W-1:0]       byte_idx;
    logic [OUT_WIDTH-1:0]   pack_reg;
    logic [OUT_WIDTH-1:0]   lane_mask;
    entry_t                 commit_word;
    entry_t                 head;
    entry_t                 mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   full;
    logic                   accept;
    logic                   commit;
    logic                   pop;

    // in_rdy looks only at the registered level, so a pop in the same cycle
    // cannot open the input; it is also held low for the whole reset.
    assign full       = (level == LEVEL_FULL);
    assign bus.in_rdy = rst_n & ~full;
    assign accept     = bus.in_vld & bus.in_rdy;
    assign commit     = accept & ((byte_idx == LAST_LANE) | bus.in_last);
    assign bus.out_vld = (level != '0);
    assign pop        = bus.out_vld & bus.out_rdy;

    // The word being committed combines the lanes already packed below
    // byte_idx with the incoming byte; everything above byte_idx is forced to 0
    // so a short final word is cleanly zero-padded.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(byte_idx)) begin
                lane_mask[i*IN_WIDTH +: IN_WIDTH] = '1;
            end
        end
        commit_word.data = (pack_reg & lane_mask)
                         | (OUT_WIDTH'(bus.in_data) << (int'(byte_idx) * IN_WIDTH));
        commit_word.cnt  = CNT_W'(byte_idx) + CNT_W'(1);
        commit_word.last = bus.in_last;
    end

    // Packer: drop each accepted byte into its lane; on a commit the lane
    // register is cleared and the index restarts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            pack_reg <= '0;
        end else if (accept) begin
            if (commit) begin
                byte_idx <= '0;
                pack_reg <= '0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                pack_reg[int'(byte_idx)*IN_WIDTH +: IN_WIDTH] <= bus.in_data;
            end
        end
    end

    // FIFO bookkeeping: pointers wrap naturally at the depth; a simultaneous
    // commit and pop moves both pointers and leaves level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (commit && !pop) begin
                level <= level + 1'b1;
            end else if (!commit && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage needs no reset: a commit requires in_rdy, which is low in reset,
    // and the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr] <= commit_word;
        end
    end

    // First-word-fall-through head; outputs read as zero while empty so they
    // are clean in and right after reset.
    always_comb begin
        head         = mem[rd_ptr];
        bus.out_data = '0;
        bus.out_last = 1'b0;
        bus.out_cnt  = '0;
        if (bus.out_vld) begin
            bus.out_data = head.data;
            bus.out_last = head.last;
            bus.out_cnt  = head.cnt;
        end
    end
endmodule

// File: tb/tb_rx_fifo_packer.sv
// tb_rx_fifo_packer
//  Self-checking bench for rx_fifo_packer. A behavioural model keeps the
//  bytes of the word under construction and the list of committed words;
//  every cycle the DUT handshake, level and head word are compared to it.
module tb_rx_fifo_packer;
    typedef struct {
        logic [127:0] data;
        logic [4:0]   cnt;
        logic         last;
    } word_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   level;
    int           total = 0;
    int           bad   = 0;
    word_t        model_q[$];
    logic [7:0]   pend_q[$];
    logic [127:0] pop_data = '0;
    logic [4:0]   pop_cnt  = '0;
    logic         pop_last = 1'b0;

    rx_fifo_packer_if bus ();

    rx_fifo_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .level (level)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle from a negedge, checks the DUT against the model just
    // before the active edge, then advances the model by the handshakes the
    // rules say happen at that edge.
    task automatic applyStimulus(input logic vld, input logic [7:0] data, input logic last,
                                 input logic rdy, output bit accepted);
        bit    was_full;
        word_t w;
        bus.in_vld  = vld;
        bus.in_data = data;
        bus.in_last = last;
        bus.out_rdy = rdy;
        #1;
        was_full = (model_q.size() == 16);
        checkOutput("in_rdy", 128'(bus.in_rdy), 128'(!was_full));
        checkOutput("out_vld", 128'(bus.out_vld), 128'(model_q.size() != 0));
        checkOutput("level", 128'(level), 128'(model_q.size()));
        if (model_q.size() != 0) begin
            checkOutput("out_data", bus.out_data, model_q[0].data);
            checkOutput("out_cnt", 128'(bus.out_cnt), 128'(model_q[0].cnt));
            checkOutput("out_last", 128'(bus.out_last), 128'(model_q[0].last));
            if (rdy) begin
                pop_data = bus.out_data;
                pop_cnt  = bus.out_cnt;
                pop_last = bus.out_last;
                void'(model_q.pop_front());
            end
        end
        accepted = vld && !was_full;
        if (accepted) begin
            pend_q.push_back(data);
            if (last || pend_q.size() == 16) begin
                w.data = '0;
                foreach (pend_q[j]) w.data[8*j +: 8] = pend_q[j];
                w.cnt  = 5'(pend_q.size());
                w.last = last;
                model_q.push_back(w);
                pend_q.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pops until the model is empty (bounded), then confirms the DUT is empty.
    task automatic drain_fifo();
        bit acc;
        for (int k = 0; k < 40 && model_q.size() != 0; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        end
        checkOutput("drain_level", 128'(level), 128'(0));
    endtask

    initial begin
        bit         acc;
        int         idx;
        int         cyc;
        int         len;
        int         guard;
        logic [7:0] byte_val;
        logic       vld;
        logic       rdy;

        bus.in_vld  = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.out_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_rdy", 128'(bus.in_rdy), 128'(0));
        checkOutput("rst_out_vld", 128'(bus.out_vld), 128'(0));
        checkOutput("rst_out_data", bus.out_data, 128'(0));
        checkOutput("rst_out_last", 128'(bus.out_last), 128'(0));
        checkOutput("rst_out_cnt", 128'(bus.out_cnt), 128'(0));
        checkOutput("rst_level", 128'(level), 128'(0));
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Full 16-byte packet 00..0F
        for (int b = 0; b < 16; b++) begin
            applyStimulus(1'b1, 8'(b), b == 15, 1'b1, acc);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        checkOutput("t1_data", pop_data, 128'h0F0E0D0C0B0A09080706050403020100);
        checkOutput("t1_cnt", 128'(pop_cnt), 128'(16));
        checkOutput("t1_last", 128'(pop_last), 128'(1));

        // Short packet AA BB CC
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        checkOutput("t2_data", pop_data, 128'hCCBBAA);
        checkOutput("t2_cnt", 128'(pop_cnt), 128'(3));
        checkOutput("t2_last", 128'(pop_last), 128'(1));
        drain_fifo();

        // Fill to 16 words with the consumer stalled, then hold a byte at full
        $display("[TB] fill to full");
        idx = 0;
        cyc = 0;
        while (idx < 256 && cyc < 2000) begin
            applyStimulus(1'b1, 8'(idx) ^ 8'h5A, (idx % 32) == 31, 1'b0, acc);
            if (acc) idx++;
            cyc++;
        end
        repeat (4) applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, acc);
        checkOutput("full_level", 128'(level), 128'(16));
        checkOutput("full_in_rdy", 128'(bus.in_rdy), 128'(0));
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 40) begin
            applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, acc);
            cyc++;
        end
        drain_fifo();

        // Level 5 with commit and pop in the same cycle, across pointer wrap
        $display("[TB] simultaneous commit/pop");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'h10 + 8'(k), 1'b1, 1'b0, acc);
        end
        checkOutput("l5_level", 128'(level), 128'(5));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b1, acc);
            checkOutput("simul_level", 128'(level), 128'(5));
        end
        drain_fifo();

        // Reset in the middle of a word with a word already buffered
        $display("[TB] mid-word reset");
        for (int b = 0; b < 16; b++) begin
            applyStimulus(1'b1, 8'h60 + 8'(b), 1'b0, 1'b0, acc);
        end
        for (int b = 0; b < 7; b++) begin
            applyStimulus(1'b1, 8'h70 + 8'(b), 1'b0, 1'b0, acc);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_vld", 128'(bus.out_vld), 128'(0));
        checkOutput("mid_rst_in_rdy", 128'(bus.in_rdy), 128'(0));
        checkOutput("mid_rst_level", 128'(level), 128'(0));
        checkOutput("mid_rst_out_data", bus.out_data, 128'(0));
        checkOutput("mid_rst_out_cnt", 128'(bus.out_cnt), 128'(0));
        checkOutput("mid_rst_out_last", 128'(bus.out_last), 128'(0));
        model_q.delete();
        pend_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 16; b++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(b), b == 15, 1'b1, acc);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        checkOutput("t5_data", pop_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        checkOutput("t5_cnt", 128'(pop_cnt), 128'(16));
        drain_fifo();

        // Random traffic: 1000 packets of 1..100 bytes
        $display("[TB] random packets");
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 100);
            for (int b = 0; b < len; b++) begin
                byte_val = 8'($urandom);
                acc      = 1'b0;
                guard    = 0;
                while (!acc) begin
                    vld = ($urandom_range(0, 7) != 0);
                    rdy = ($urandom_range(0, 3) != 0);
                    applyStimulus(vld, vld ? byte_val : 8'($urandom), vld && (b == len - 1), rdy, acc);
                    guard++;
                    if (!acc && guard >= 200) begin
                        total++;
                        bad++;
                        $error("[TB] FAIL byte_timeout observed=stalled expected=accepted");
                        break;
                    end
                end
            end
        end
        drain_fifo();
        checkOutput("final_out_vld", 128'(bus.out_vld), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
